sys_onchip_mem_master: RTL and testbench
========================================

Name: sys_onchip_mem_master

Overview:
- Avalon-MM master engine that drives the s1 port of a single-port on-chip RAM (32-bit data, 10-bit word address, fixed read latency, no waitrequest).
- Three operations on that one port: fill a region with a constant, copy a region forward, or check a region against a constant and count mismatches.
- Sits between the system control/CSR logic and the RAM. Used for boot-time clearing, scratch-buffer moves and memory self-test.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, RAM data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from the address-sampling edge to valid readdata (1 = unregistered RAM output, 2 = registered).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- op  in  2  0 = FILL, 1 = COPY, 2 = CHECK, 3 = reserved (treated as no-op, done pulses).
- src_addr  in  ADDR_W  COPY source start word.
- dst_addr  in  ADDR_W  FILL/COPY destination start word, CHECK start word.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- pattern  in  DATA_W  FILL value and CHECK compare value.
- abort  in  1  stop the current operation.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 if the operation ended by abort.
- err_count  out  ADDR_W+1  CHECK mismatch count; holds until the next start.
- address  out  ADDR_W  RAM address.
- byteenable  out  DATA_W/8  constant all-ones.
- chipselect  out  1  RAM chipselect.
- write  out  1  RAM write.
- writedata  out  DATA_W  RAM write data.
- clken  out  1  constant 1.
- readdata  in  DATA_W  RAM read data.

Behaviour:
- Reset values: busy 0, done 0, aborted 0, err_count 0, address 0, chipselect 0, write 0, writedata 0. byteenable and clken are constant all-ones/1.
- All bus outputs are registered. No RAM access ever happens outside the access states listed below.
- Start capture: in IDLE with start=1, latch op, both addresses, len and pattern into working registers, and clear err_count.
  - If len=0 or op=3, go to DONE with no bus activity.
  - Otherwise go to the first access state.
  - start while busy is ignored.
- FILL: WR state only.
  - Each cycle: chipselect=1, write=1, address=dst, writedata=pattern.
  - 1 cycle per word; dst increments after each word.
- COPY: RD, then WAIT, then WR, repeated per word.
  - RD (1 cycle): chipselect=1, write=0, address=src.
  - WAIT (READ_LATENCY cycles): chipselect=0. readdata is captured into a data register on the last WAIT cycle.
  - WR (1 cycle): write the captured word to dst.
  - 2+READ_LATENCY cycles per word. src and dst increment after WR.
  - Always ascending. An overlap with dst>src within len corrupts data; that is documented and not detected.
- CHECK: RD then WAIT per word.
  - On the capture cycle, if readdata != pattern, err_count increments.
  - 1+READ_LATENCY cycles per word.
- Addresses wrap modulo 2^ADDR_W; 1023+1 goes to 0. len=2^ADDR_W covers the whole RAM exactly once.
- A word counter decrements once per completed word. Leaving the last word goes to DONE.
- DONE (1 cycle): done=1, busy=0 in the same cycle, chipselect=0, then IDLE.
- abort while busy:
  - The next state is DONE with aborted=1.
  - A read whose data has not been captured is dropped; a pending copy write is not issued.
  - Words already written stay written.
  - err_count keeps the mismatches counted so far.
  - If abort and the final word complete in the same cycle, completion wins (aborted=0).
  - abort in IDLE is ignored.
- start and abort together in IDLE: start is accepted and abort is ignored.
- Asynchronous reset mid-operation returns to IDLE and the reset values immediately. No done pulse is produced.

Decomposition:
- Shared package sys_mem_pkg holds:
  - op encodings OP_FILL / OP_COPY / OP_CHECK / OP_NOP;
  - the state enum IDLE / RD / WAIT / WR / DONE;
  - defaults for ADDR_W and DATA_W.
- No sub-module. One FSM plus a datapath of an address pair, word counter, latency counter, data register and mismatch counter.

Test Plan:
- FILL at dst=0x3F0, len=32, pattern=0xA5A5_5AA5 → 32 consecutive write cycles to addresses 0x3F0..0x3FF then 0x000..0x00F. done arrives 33 cycles after start. A readback matches the pattern.
- COPY src=0x010, dst=0x200, len=4 with RAM[0x10..0x13]=1,2,3,4 and READ_LATENCY=1 → 12 bus-active cycles plus DONE. RAM[0x200..0x203]=1,2,3,4. Source is unchanged.
- CHECK dst=0, len=8, pattern=0 with RAM[3]=0xFF and RAM[6]=0x1 → err_count=2, aborted=0. No write is ever asserted.
- len=0 with op=COPY → done the cycle after start, chipselect never asserted. op=3 behaves the same.
- FILL len=100 with abort asserted on the 10th write cycle → exactly 10 words written, done=1 with aborted=1. start pulses during busy are ignored.
- Reset asserted mid-COPY between RD and WR → chipselect, write and busy drop asynchronously. The destination word is not written and no done pulse occurs.

Source files
------------

// File: rtl/sys_mem_pkg.sv
// Shared types for the on-chip RAM master engine: operation codes, FSM states
// and default bus widths.
package sys_mem_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_FILL  = 2'd0,
      OP_COPY  = 2'd1,
      OP_CHECK = 2'd2,
      OP_NOP   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      DONE
   } state_e;

endpackage

// File: rtl/sys_onchip_mem_master.sv
// Avalon-MM master driving the s1 port of a single-port on-chip RAM with
// fill, forward-copy and check-against-constant operations.
module sys_onchip_mem_master
   import sys_mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [ADDR_W:0]     len,
   input  logic [DATA_W-1:0]   pattern,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [ADDR_W:0]     err_count,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W+1)'(1);

   state_e              state, next_state;
   op_e                 op_q, op_n;
   logic [ADDR_W-1:0]   src_q, src_n;
   logic [ADDR_W-1:0]   dst_q, dst_n;
   logic [ADDR_W:0]     cnt_q, cnt_n;
   logic [LAT_W-1:0]    lat_q, lat_n;
   logic [DATA_W-1:0]   data_q, data_n;
   logic [DATA_W-1:0]   pat_q, pat_n;
   logic [ADDR_W:0]     err_n;
   logic                abort_end;

   logic                busy_d, done_d, aborted_d, chipselect_d, write_d;
   logic [ADDR_W-1:0]   address_d;
   logic [DATA_W-1:0]   writedata_d;

   assign byteenable = '1;
   assign clken      = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state plus next datapath values; the read pointer src also serves CHECK.
   always_comb begin
      next_state = state;
      op_n       = op_q;
      src_n      = src_q;
      dst_n      = dst_q;
      cnt_n      = cnt_q;
      lat_n      = lat_q;
      data_n     = data_q;
      pat_n      = pat_q;
      err_n      = err_count;
      abort_end  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               op_n  = op_e'(op);
               src_n = (op_e'(op) == OP_CHECK) ? dst_addr : src_addr;
               dst_n = dst_addr;
               cnt_n = len;
               pat_n = pattern;
               err_n = '0;
               if (len == '0 || op_e'(op) == OP_NOP) begin
                  next_state = DONE;
               end else if (op_e'(op) == OP_FILL) begin
                  next_state = WR;
               end else begin
                  next_state = RD;
               end
            end
         end
         RD: begin
            if (abort) begin
               next_state = DONE;
               abort_end  = 1'b1;
            end else begin
               next_state = WAIT;
               lat_n      = LAT_LAST;
            end
         end
         WAIT: begin
            if (lat_q != '0) begin
               lat_n = lat_q - LAT_W'(1);
               if (abort) begin
                  next_state = DONE;
                  abort_end  = 1'b1;
               end
            end else begin
               data_n = readdata;
               if (op_q == OP_CHECK) begin
                  if (readdata != pat_q) begin
                     err_n = err_count + (ADDR_W+1)'(1);
                  end
                  src_n = src_q + ADDR_W'(1);
                  cnt_n = cnt_q - (ADDR_W+1)'(1);
                  if (cnt_q == LAST_WORD) begin
                     next_state = DONE;
                  end else if (abort) begin
                     next_state = DONE;
                     abort_end  = 1'b1;
                  end else begin
                     next_state = RD;
                  end
               end else if (abort) begin
                  next_state = DONE;
                  abort_end  = 1'b1;
               end else begin
                  next_state = WR;
               end
            end
         end
         WR: begin
            dst_n = dst_q + ADDR_W'(1);
            cnt_n = cnt_q - (ADDR_W+1)'(1);
            if (op_q == OP_COPY) begin
               src_n = src_q + ADDR_W'(1);
            end
            if (cnt_q == LAST_WORD) begin
               next_state = DONE;
            end else if (abort) begin
               next_state = DONE;
               abort_end  = 1'b1;
            end else begin
               next_state = (op_q == OP_FILL) ? WR : RD;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Bus outputs are registered, so they are derived from the state being entered.
   always_comb begin
      busy_d       = (next_state == RD) || (next_state == WAIT) || (next_state == WR);
      done_d       = (next_state == DONE);
      aborted_d    = abort_end;
      chipselect_d = (next_state == RD) || (next_state == WR);
      write_d      = (next_state == WR);
      address_d    = address;
      writedata_d  = writedata;
      if (next_state == RD) begin
         address_d = src_n;
      end else if (next_state == WR) begin
         address_d   = dst_n;
         writedata_d = (op_n == OP_FILL) ? pat_n : data_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= OP_NOP;
         src_q     <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         lat_q     <= '0;
         data_q    <= '0;
         pat_q     <= '0;
         err_count <= '0;
      end else begin
         op_q      <= op_n;
         src_q     <= src_n;
         dst_q     <= dst_n;
         cnt_q     <= cnt_n;
         lat_q     <= lat_n;
         data_q    <= data_n;
         pat_q     <= pat_n;
         err_count <= err_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         writedata  <= '0;
      end else begin
         busy       <= busy_d;
         done       <= done_d;
         aborted    <= aborted_d;
         chipselect <= chipselect_d;
         write      <= write_d;
         address    <= address_d;
         writedata  <= writedata_d;
      end
   end

endmodule

// File: tb/tb_sys_onchip_mem_master.sv
// Bench for sys_onchip_mem_master: a behavioural RAM on the s1 port plus a
// word-array reference model of fill/copy/check.
module tb_sys_onchip_mem_master;

   localparam int RL    = 1;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [1:0]  op;
   logic [9:0]  src_addr, dst_addr;
   logic [10:0] len;
   logic [31:0] pattern;
   logic        busy, done, aborted, chipselect, write, clken;
   logic [10:0] err_count;
   logic [9:0]  address;
   logic [3:0]  byteenable;
   logic [31:0] writedata, readdata;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   sys_onchip_mem_master #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
      .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .err_count(err_count), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .write(write), .writedata(writedata),
      .clken(clken), .readdata(readdata)
   );

   // RAM with one cycle of read latency, a backdoor load port and bus activity counters.
   logic [31:0] mem [DEPTH];
   logic [31:0] rd_q;
   logic        bd_we;
   logic [9:0]  bd_addr;
   logic [31:0] bd_data;
   int          wr_cnt = 0, cs_cnt = 0, done_cnt = 0;
   logic [9:0]  wr_log [$];

   assign readdata = rd_q;

   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (chipselect && write) begin
         mem[address] <= writedata;
         wr_log.push_back(address);
      end
      if (chipselect && write) wr_cnt <= wr_cnt + 1;
      if (chipselect) begin
         cs_cnt <= cs_cnt + 1;
         rd_q   <= mem[address];
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   logic [31:0] exp_mem [DEPTH];

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) n++;
      return n;
   endfunction

   function automatic int exp_cycles(int o, int l);
      if (l == 0 || o == 3) return 1;
      if (o == 0) return l + 1;
      if (o == 1) return (2 + RL) * l + 1;
      return (1 + RL) * l + 1;
   endfunction

   function automatic int exp_cs(int o, int l);
      if (o == 3) return 0;
      return (o == 1) ? 2 * l : l;
   endfunction

   function automatic int exp_writes(int o, int l);
      return (o == 0 || o == 1) ? l : 0;
   endfunction

   // Sequential word-by-word meaning of each operation over a modulo-1024 address space.
   task automatic model_apply(input int o, input int s, input int d, input int l,
                              input logic [31:0] p, output int exp_err);
      exp_err = 0;
      for (int i = 0; i < l; i++) begin
         case (o)
            0: exp_mem[(d + i) % DEPTH] = p;
            1: exp_mem[(d + i) % DEPTH] = exp_mem[(s + i) % DEPTH];
            2: if (exp_mem[(d + i) % DEPTH] != p) exp_err++;
            default: ;
         endcase
      end
   endtask

   task automatic backdoor_write(input int a, input logic [31:0] v);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = 10'(a);
      bd_data = v;
      exp_mem[a] = v;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Issues one command and waits (bounded) for done; optionally aborts on the Nth write
   // and throws random start pulses at the busy engine.
   task automatic do_cmd(input logic [1:0] o, input logic [9:0] s, input logic [9:0] d,
                         input logic [10:0] l, input logic [31:0] p, input int abort_at,
                         input bit noisy, output int cyc, output bit got_done,
                         output bit got_aborted, output logic [10:0] got_err);
      int w0, limit;
      w0    = wr_cnt;
      limit = 4 * int'(l) + 20;
      @(negedge clk);
      op = o; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
      cyc = 0; got_done = 1'b0; got_aborted = 1'b0; got_err = '0;
      for (int i = 1; i <= limit && !got_done; i++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (done) begin
            got_done    = 1'b1;
            cyc         = i;
            got_aborted = aborted;
            got_err     = err_count;
         end else begin
            if (noisy) begin
               start    = 1'($urandom_range(0, 1));
               op       = 2'($urandom);
               src_addr = 10'($urandom);
               dst_addr = 10'($urandom);
               len      = 11'($urandom);
               pattern  = $urandom;
            end
            if (abort_at > 0 && write && (wr_cnt - w0) == abort_at - 1) abort = 1'b1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; src_addr = '0; dst_addr = '0;
      len = '0; pattern = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      repeat (3) @(negedge clk);
      compared++;
      if ({busy, done, aborted, chipselect, write} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, aborted, chipselect, write});
      end
      compared++;
      if (err_count !== 11'd0 || address !== 10'd0 || writedata !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_regs: got err=%0h addr=%0h wd=%0h expected 0 0 0", err_count, address, writedata);
      end
      compared++;
      if (byteenable !== 4'hF || clken !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_consts: got be=%h clken=%b expected f 1", byteenable, clken);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({busy, chipselect, done} !== 3'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_quiet: got %b expected 000", {busy, chipselect, done});
      end
   endtask

   task automatic preload_all();
      for (int i = 0; i < DEPTH; i++) backdoor_write(i, 32'($urandom_range(0, 3)));
   endtask

   task automatic test_fill_wrap();
      int cyc, w0, l0, bad, exp_err;
      bit gd, ga;
      logic [10:0] ge;
      w0 = wr_cnt;
      l0 = wr_log.size();
      do_cmd(2'd0, 10'h000, 10'h3F0, 11'd32, 32'hA5A5_5AA5, 0, 1'b0, cyc, gd, ga, ge);
      model_apply(0, 0, 'h3F0, 32, 32'hA5A5_5AA5, exp_err);
      compared++;
      if (!gd || cyc != 33) begin
         mismatched++;
         $display("[TB] FAIL fill_done_cycle: got done=%b at %0d expected done at 33", gd, cyc);
      end
      compared++;
      if (wr_cnt - w0 != 32 || ga !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL fill_writes: got %0d aborted=%b expected 32 aborted=0", wr_cnt - w0, ga);
      end
      bad = 0;
      if (wr_log.size() < l0 + 32) bad = 32;
      else for (int i = 0; i < 32; i++) if (wr_log[l0 + i] !== 10'((16'h3F0 + i) % DEPTH)) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL fill_addr_seq: got %0d wrong addresses expected 0", bad);
      end
      compared++;
      if (mem_diff() != 0) begin
         mismatched++;
         $display("[TB] FAIL fill_mem: got %0d differing words expected 0", mem_diff());
      end
      w0 = wr_cnt;
      do_cmd(2'd2, 10'h000, 10'h3F0, 11'd32, 32'hA5A5_5AA5, 0, 1'b0, cyc, gd, ga, ge);
      compared++;
      if (!gd || ge !== 11'd0 || wr_cnt != w0) begin
         mismatched++;
         $display("[TB] FAIL fill_readback: got done=%b err=%0d writes=%0d expected 1 0 0", gd, ge, wr_cnt - w0);
      end
   endtask

   task automatic test_copy();
      int cyc, w0, c0, bad, exp_err;
      bit gd, ga;
      logic [10:0] ge;
      for (int i = 0; i < 4; i++) backdoor_write('h10 + i, 32'(i + 1));
      w0 = wr_cnt;
      c0 = cs_cnt;
      do_cmd(2'd1, 10'h010, 10'h200, 11'd4, 32'h0, 0, 1'b0, cyc, gd, ga, ge);
      model_apply(1, 'h10, 'h200, 4, 32'h0, exp_err);
      compared++;
      if (!gd || cyc != 13 || ga !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL copy_done_cycle: got done=%b at %0d aborted=%b expected 13 0", gd, cyc, ga);
      end
      compared++;
      if (cs_cnt - c0 != 8 || wr_cnt - w0 != 4) begin
         mismatched++;
         $display("[TB] FAIL copy_bus: got cs=%0d wr=%0d expected 8 4", cs_cnt - c0, wr_cnt - w0);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) if (mem['h200 + i] !== 32'(i + 1)) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL copy_dest: got %0d wrong words expected 0", bad);
      end
      compared++;
      if (mem_diff() != 0) begin
         mismatched++;
         $display("[TB] FAIL copy_mem: got %0d differing words expected 0", mem_diff());
      end
   endtask

   task automatic test_check();
      int cyc, w0, exp_err;
      bit gd, ga;
      logic [10:0] ge;
      for (int i = 0; i < 8; i++) backdoor_write(i, (i == 3) ? 32'hFF : (i == 6) ? 32'h1 : 32'h0);
      w0 = wr_cnt;
      do_cmd(2'd2, 10'h155, 10'h000, 11'd8, 32'h0, 0, 1'b0, cyc, gd, ga, ge);
      model_apply(2, 0, 0, 8, 32'h0, exp_err);
      compared++;
      if (ge !== 11'd2 || ge !== 11'(exp_err)) begin
         mismatched++;
         $display("[TB] FAIL check_errs: got %0d expected 2", ge);
      end
      compared++;
      if (!gd || cyc != 17 || ga !== 1'b0 || wr_cnt != w0) begin
         mismatched++;
         $display("[TB] FAIL check_timing: got done=%b cyc=%0d ab=%b wr=%0d expected 1 17 0 0", gd, cyc, ga, wr_cnt - w0);
      end
   endtask

   task automatic test_zero_len();
      int cyc, c0;
      bit gd, ga;
      logic [10:0] ge;
      c0 = cs_cnt;
      do_cmd(2'd1, 10'h010, 10'h020, 11'd0, 32'h0, 0, 1'b0, cyc, gd, ga, ge);
      compared++;
      if (!gd || cyc != 1 || cs_cnt != c0) begin
         mismatched++;
         $display("[TB] FAIL zero_len: got done=%b cyc=%0d cs=%0d expected 1 1 0", gd, cyc, cs_cnt - c0);
      end
      c0 = cs_cnt;
      do_cmd(2'd3, 10'h010, 10'h020, 11'd7, 32'h0, 0, 1'b0, cyc, gd, ga, ge);
      compared++;
      if (!gd || cyc != 1 || cs_cnt != c0 || ga !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL nop_op: got done=%b cyc=%0d cs=%0d expected 1 1 0", gd, cyc, cs_cnt - c0);
      end
   endtask

   task automatic test_abort();
      int cyc, w0, exp_err;
      bit gd, ga;
      logic [10:0] ge;
      w0 = wr_cnt;
      do_cmd(2'd0, 10'h000, 10'h0C0, 11'd100, 32'h1234_5678, 10, 1'b1, cyc, gd, ga, ge);
      model_apply(0, 0, 'h0C0, 10, 32'h1234_5678, exp_err);
      compared++;
      if (!gd || ga !== 1'b1 || cyc != 11) begin
         mismatched++;
         $display("[TB] FAIL abort_done: got done=%b aborted=%b cyc=%0d expected 1 1 11", gd, ga, cyc);
      end
      compared++;
      if (wr_cnt - w0 != 10) begin
         mismatched++;
         $display("[TB] FAIL abort_words: got %0d expected 10", wr_cnt - w0);
      end
      compared++;
      if (mem_diff() != 0) begin
         mismatched++;
         $display("[TB] FAIL abort_mem: got %0d differing words expected 0", mem_diff());
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         int o, s, d, l, exp_err, cyc, w0, c0;
         logic [31:0] p;
         bit gd, ga;
         logic [10:0] ge;
         o = $urandom_range(0, 3);
         s = $urandom_range(0, DEPTH - 1);
         d = $urandom_range(0, DEPTH - 1);
         l = (it == 3) ? DEPTH : $urandom_range(0, 40);
         p = (o == 2) ? 32'($urandom_range(0, 3)) : $urandom;
         w0 = wr_cnt;
         c0 = cs_cnt;
         do_cmd(2'(o), 10'(s), 10'(d), 11'(l), p, 0, (it % 2) == 1, cyc, gd, ga, ge);
         model_apply(o, s, d, l, p, exp_err);
         compared++;
         if (!gd || cyc != exp_cycles(o, l) || ga !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rand_done it%0d: got done=%b cyc=%0d ab=%b expected cyc=%0d ab=0", it, gd, cyc, ga, exp_cycles(o, l));
         end
         compared++;
         if (ge !== 11'(exp_err)) begin
            mismatched++;
            $display("[TB] FAIL rand_err it%0d: got %0d expected %0d", it, ge, exp_err);
         end
         compared++;
         if (wr_cnt - w0 != exp_writes(o, l) || cs_cnt - c0 != exp_cs(o, l)) begin
            mismatched++;
            $display("[TB] FAIL rand_bus it%0d: got wr=%0d cs=%0d expected %0d %0d", it, wr_cnt - w0, cs_cnt - c0, exp_writes(o, l), exp_cs(o, l));
         end
         compared++;
         if (mem_diff() != 0) begin
            mismatched++;
            $display("[TB] FAIL rand_mem it%0d: got %0d differing words expected 0", it, mem_diff());
         end
      end
   endtask

   task automatic test_reset_mid();
      int d0, exp_err;
      @(negedge clk);
      op = 2'd1; src_addr = 10'h040; dst_addr = 10'h300; len = 11'd4; pattern = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({chipselect, write, busy} !== 3'b101) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_rd_phase: got %b expected 101", {chipselect, write, busy});
      end
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      compared++;
      if ({chipselect, write, busy, done} !== 4'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_async: got %b expected 0000", {chipselect, write, busy, done});
      end
      model_apply(1, 'h040, 'h300, 1, 32'h0, exp_err);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (done_cnt != d0 || address !== 10'd0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_after: got dones=%0d addr=%0h expected 0 0", done_cnt - d0, address);
      end
      compared++;
      if (mem_diff() != 0) begin
         mismatched++;
         $display("[TB] FAIL rst_mid_mem: got %0d differing words expected 0", mem_diff());
      end
   endtask

   initial begin
      test_reset();
      preload_all();
      test_fill_wrap();
      test_copy();
      test_check();
      test_zero_len();
      test_abort();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
